flp_addsub_seq: RTL and testbench

Sequential, area-lean floating point add/subtract unit for the VxEngine FLP library: the operand-consuming counterpart that wraps the combinational adder datapath into a multi-cycle unit with a valid/ready input handshake and a registered result strobe. Alignment and normalization shift one bit per cycle under an FSM, so latency is data-dependent. It is intended as the shared FP add/sub resource behind vector lanes, where throughput matters less than area.

---
 rtl/flp_pkg.sv | 32 +++
 rtl/flp_addsub_round.sv | 42 ++++
 rtl/flp_addsub_seq.sv | 185 ++++++++++++++++++
 tb/tb_flp_addsub_seq.sv | 123 ++++++++++++
 4 files changed

// File: rtl/flp_pkg.sv
// Shared definitions for the FLP library: FSM state encoding, canonical
// special-value patterns and IEEE field helpers, all sized by EWIDTH/SWIDTH.
package flp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } flp_state_t;

  // Exponent all ones, significand MSB set, sign 0.
  function automatic logic [63:0] qnan_bits(input int ew, input int sw);
    return (((64'd1 << ew) - 64'd1) << sw) | (64'd1 << (sw - 1));
  endfunction

  // Exponent all ones, significand zero, sign 0.
  function automatic logic [63:0] inf_bits(input int ew, input int sw);
    return ((64'd1 << ew) - 64'd1) << sw;
  endfunction

  function automatic logic [63:0] exp_field(input logic [63:0] x, input int ew, input int sw);
    return (x >> sw) & ((64'd1 << ew) - 64'd1);
  endfunction

  function automatic logic [63:0] frac_field(input logic [63:0] x, input int sw);
    return x & ((64'd1 << sw) - 64'd1);
  endfunction

endpackage

// File: rtl/flp_addsub_round.sv
// Combinational round-to-nearest-even of a normalized significand, with
// exponent bump on rounding overflow and saturation to signed infinity.
module flp_addsub_round
  import flp_pkg::*;
#(
  parameter int EWIDTH  = 8,
  parameter int SWIDTH  = 23,
  parameter int RSWIDTH = 2
) (
  input  logic                        sign,
  input  logic [EWIDTH:0]             exp_in,
  input  logic [SWIDTH+RSWIDTH+1:0]   man,     // hidden, fraction, guard/round, sticky
  output logic [EWIDTH+SWIDTH:0]      result
);

  localparam logic [63:0] INF64 = inf_bits(EWIDTH, SWIDTH);
  localparam logic [EWIDTH:0] EMAX = {1'b0, {EWIDTH{1'b1}}};

  logic [SWIDTH:0]   keep;
  logic              guard;
  logic              rest;
  logic              up;
  logic [SWIDTH+1:0] rnd;
  logic [EWIDTH:0]   exp_r;
  logic [SWIDTH-1:0] frac;

  always_comb begin
    keep  = man[SWIDTH+RSWIDTH+1:RSWIDTH+1];
    guard = man[RSWIDTH];
    rest  = |man[RSWIDTH-1:0];
    up    = guard & (rest | keep[0]);
    rnd   = {1'b0, keep} + (SWIDTH+2)'(up);
    exp_r = exp_in + (EWIDTH+1)'(rnd[SWIDTH+1]);
    // A carry out of rounding leaves 1.000..0, so the fraction is the shifted sum.
    frac  = rnd[SWIDTH+1] ? rnd[SWIDTH:1] : rnd[SWIDTH-1:0];
    if (exp_r >= EMAX)
      result = {sign, INF64[EWIDTH+SWIDTH-1:0]};
    else
      result = {sign, exp_r[EWIDTH-1:0], frac};
  end

endmodule

// File: rtl/flp_addsub_seq.sv
// Multi-cycle FP add/subtract: one-bit-per-cycle alignment and normalization
// under an FSM, valid/ready operand capture and a one-cycle result strobe.
module flp_addsub_seq
  import flp_pkg::*;
#(
  parameter int EWIDTH  = 8,
  parameter int SWIDTH  = 23,
  parameter int RSWIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [EWIDTH+SWIDTH:0] i_a,
  input  logic [EWIDTH+SWIDTH:0] i_b,
  input  logic                   i_sub,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [EWIDTH+SWIDTH:0] o_p,
  output logic                   o_valid
);

  // Handshake: operands are taken on a rising edge with i_valid & o_ready;
  // o_ready stays low until the result strobe o_valid has been issued.
  localparam int W    = EWIDTH + SWIDTH + 1;
  localparam int M    = 1 + SWIDTH + RSWIDTH;
  localparam int MAXD = SWIDTH + RSWIDTH + 2;
  localparam int CW   = $clog2(MAXD + 1);
  localparam logic [63:0]     QNAN64 = qnan_bits(EWIDTH, SWIDTH);
  localparam logic [EWIDTH:0] EXP_ONE = (EWIDTH+1)'(1);

  flp_state_t        state;
  logic [M-1:0]      sa, sb;
  logic              stk;
  logic [CW-1:0]     cnt;
  logic [EWIDTH:0]   ex;
  logic [M+1:0]      man;
  logic              sgn, eff_sub;

  logic [EWIDTH-1:0] a_e, b_e, big_e, small_e, diff;
  logic [SWIDTH-1:0] a_f, b_f, big_f, small_f;
  logic              a_s, b_s, big_s, small_s;
  logic              a_z, b_z, a_inf, b_inf, a_nan, b_nan, spec;
  logic [W-1:0]      spec_p;
  logic [CW-1:0]     d_ld;
  logic [M+1:0]      a_ext, b_ext, add_res;
  logic [W-1:0]      rnd_p;

  always_comb begin
    a_e   = EWIDTH'(exp_field(64'(i_a), EWIDTH, SWIDTH));
    b_e   = EWIDTH'(exp_field(64'(i_b), EWIDTH, SWIDTH));
    a_f   = SWIDTH'(frac_field(64'(i_a), SWIDTH));
    b_f   = SWIDTH'(frac_field(64'(i_b), SWIDTH));
    a_s   = i_a[W-1];
    b_s   = i_b[W-1] ^ i_sub;
    // Zero exponent covers denormals, which are flushed to signed zero.
    a_z   = (a_e == '0);
    b_z   = (b_e == '0);
    a_inf = (a_e == '1) && (a_f == '0);
    b_inf = (b_e == '1) && (b_f == '0);
    a_nan = (a_e == '1) && (a_f != '0);
    b_nan = (b_e == '1) && (b_f != '0);
    spec   = 1'b1;
    spec_p = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (a_s != b_s))) spec_p = QNAN64[W-1:0];
    else if (a_inf)        spec_p = {a_s, a_e, a_f};
    else if (b_inf)        spec_p = {b_s, b_e, b_f};
    else if (a_z && b_z)   spec_p = {a_s & b_s, {(W-1){1'b0}}};
    else if (a_z)          spec_p = {b_s, b_e, b_f};
    else if (b_z)          spec_p = {a_s, a_e, a_f};
    else                   spec   = 1'b0;

    if ({b_e, b_f} > {a_e, a_f}) begin
      big_e = b_e; big_f = b_f; big_s = b_s;
      small_e = a_e; small_f = a_f; small_s = a_s;
    end else begin
      big_e = a_e; big_f = a_f; big_s = a_s;
      small_e = b_e; small_f = b_f; small_s = b_s;
    end
    diff = big_e - small_e;
    d_ld = (diff > EWIDTH'(MAXD)) ? CW'(MAXD) : diff[CW-1:0];

    // Sticky rides as an extra LSB so a borrow from it propagates correctly.
    a_ext   = {1'b0, sa, 1'b0};
    b_ext   = {1'b0, sb, stk};
    add_res = eff_sub ? (a_ext - b_ext) : (a_ext + b_ext);
  end

  flp_addsub_round #(
    .EWIDTH (EWIDTH),
    .SWIDTH (SWIDTH),
    .RSWIDTH(RSWIDTH)
  ) u_round (
    .sign  (sgn),
    .exp_in(ex),
    .man   (man[M:0]),
    .result(rnd_p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_p     <= '0;
      sa      <= '0;
      sb      <= '0;
      stk     <= 1'b0;
      cnt     <= '0;
      ex      <= '0;
      man     <= '0;
      sgn     <= 1'b0;
      eff_sub <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            o_ready <= 1'b0;
            if (spec) begin
              o_p     <= spec_p;
              o_valid <= 1'b1;
              state   <= ST_DONE;
            end else begin
              sa      <= {1'b1, big_f, {RSWIDTH{1'b0}}};
              sb      <= {1'b1, small_f, {RSWIDTH{1'b0}}};
              stk     <= 1'b0;
              cnt     <= d_ld;
              ex      <= {1'b0, big_e};
              sgn     <= big_s;
              eff_sub <= big_s ^ small_s;
              state   <= ST_ALIGN;
            end
          end
        end
        ST_ALIGN: begin
          if (cnt == '0) begin
            state <= ST_ADD;
          end else begin
            sb  <= {1'b0, sb[M-1:1]};
            stk <= stk | sb[0];
            cnt <= cnt - CW'(1);
          end
        end
        ST_ADD: begin
          if (add_res == '0) begin
            o_p     <= '0;
            o_valid <= 1'b1;
            state   <= ST_DONE;
          end else begin
            man   <= add_res;
            state <= ST_NORM;
          end
        end
        ST_NORM: begin
          if (man[M+1]) begin
            man   <= {1'b0, man[M+1:2], man[1] | man[0]};
            ex    <= ex + EXP_ONE;
            state <= ST_ROUND;
          end else if (!man[M]) begin
            if (ex > EXP_ONE) begin
              man <= {man[M:1], 1'b0, man[0]};
              ex  <= ex - EXP_ONE;
            end else begin
              o_p     <= {sgn, {(W-1){1'b0}}};
              o_valid <= 1'b1;
              state   <= ST_DONE;
            end
          end else begin
            state <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          o_p     <= rnd_p;
          o_valid <= 1'b1;
          state   <= ST_DONE;
        end
        ST_DONE: begin
          o_valid <= 1'b0;
          o_ready <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flp_addsub_seq.sv
// Directed self-checking bench for flp_addsub_seq (single precision):
// results, data-dependent latency, busy handshake and mid-operation reset.
module tb_flp_addsub_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_a, i_b;
  logic        i_sub, i_valid;
  logic        o_ready, o_valid;
  logic [31:0] o_p;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  flp_addsub_seq #(
    .EWIDTH (8),
    .SWIDTH (23),
    .RSWIDTH(2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .i_a    (i_a),
    .i_b    (i_b),
    .i_sub  (i_sub),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_p    (o_p),
    .o_valid(o_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // Cycle 1 is the interval right after the accepting edge.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [31:0] exp_p,
                        input logic [31:0] exp_lat, input bit stray);
    int cyc;
    bit seen;
    bit busy_bad;
    @(negedge clk);
    i_a = a; i_b = b; i_sub = sub; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_a = $urandom; i_b = $urandom; i_sub = 1'($urandom_range(0, 1));
    seen = 1'b0; busy_bad = 1'b0; cyc = 1;
    while (!seen && cyc <= 100) begin
      if (o_valid) begin
        seen = 1'b1;
      end else begin
        if (o_ready) busy_bad = 1'b1;
        if (stray && cyc == 10) i_valid = 1'b1;
        if (stray && cyc == 12) i_valid = 1'b0;
        @(posedge clk); #1;
        cyc++;
      end
    end
    check({tag, "_lat"}, seen ? 32'(cyc) : 32'd0, exp_lat);
    check({tag, "_p"}, o_p, exp_p);
    check({tag, "_busy"}, 32'(busy_bad | o_ready), 32'd0);
    @(posedge clk); #1;
    check({tag, "_after"}, {30'd0, o_valid, o_ready}, 32'd1);
  endtask

  initial begin
    bit pulsed;
    rst = 1'b1; i_valid = 1'b0; i_a = '0; i_b = '0; i_sub = 1'b0;
    #12;
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_p", o_p, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("cancel",   32'h4087ae14, 32'h4087ae14, 1'b1, 32'h00000000, 32'd3,  1'b0);
    run_op("carry_rnd",32'h40efffff, 32'h3f000007, 1'b0, 32'h41000000, 32'd8,  1'b0);
    run_op("add_d5",   32'h42043d71, 32'h3fa0fb82, 1'b0, 32'h4209454d, 32'd10, 1'b0);
    run_op("add_swap", 32'h3fa0fb82, 32'h48a2d202, 1'b0, 32'h48a2d22a, 32'd23, 1'b0);
    run_op("sub_n23",  32'h3f800001, 32'h3f800000, 1'b1, 32'h34000000, 32'd28, 1'b1);
    run_op("sub_neg",  32'h3f800000, 32'h40000000, 1'b1, 32'hbf800000, 32'd7,  1'b0);
    run_op("sat_d",    32'h3f800000, 32'h0d800000, 1'b0, 32'h3f800000, 32'd32, 1'b0);
    run_op("tie_even", 32'h3f800000, 32'h33800000, 1'b0, 32'h3f800000, 32'd29, 1'b0);
    run_op("tie_up",   32'h3f800001, 32'h33800000, 1'b0, 32'h3f800002, 32'd29, 1'b0);
    run_op("inf_nan",  32'h7f800000, 32'h7f800000, 1'b1, 32'h7fc00000, 32'd1,  1'b0);
    run_op("ovf_inf",  32'h7f7fffff, 32'h7f7fffff, 1'b0, 32'h7f800000, 32'd5,  1'b0);
    run_op("ftz_in",   32'h00000001, 32'h80000000, 1'b0, 32'h00000000, 32'd1,  1'b0);
    run_op("neg_zero", 32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 32'd1,  1'b0);
    run_op("one_zero", 32'h00000000, 32'h40490fdb, 1'b1, 32'hc0490fdb, 32'd1,  1'b0);

    // Abort a long subtraction with reset in cycle 5.
    @(negedge clk);
    i_a = 32'h3f800001; i_b = 32'h3f800000; i_sub = 1'b1; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    pulsed = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (o_valid) pulsed = 1'b1;
    end
    #1 rst = 1'b1;
    #1;
    check("abort_rst_p", o_p, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_ready", 32'(o_ready), 32'd1);
    repeat (40) begin
      @(posedge clk); #1;
      if (o_valid) pulsed = 1'b1;
    end
    check("abort_no_valid", 32'(pulsed), 32'd0);
    check("abort_idle_p", o_p, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
